// File: rtl/sync_timing_gen.sv
// Parametrised sync timing generator: own period counter, 4-phase FSM,
// sync pulse, active flag, active-region position and end-of-period strobe.
module sync_timing_gen #(
  parameter int CW       = 10,
  parameter int SYNC_LEN = 96,
  parameter int BP_LEN   = 48,
  parameter int ACT_LEN  = 640,
  parameter int FP_LEN   = 16,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE,
  output logic          SYNC,
  output logic [1:0]    ST,
  output logic          ACTIVE,
  output logic [CW-1:0] POS,
  output logic [CW-1:0] CNT,
  output logic          EOL
);

  localparam int TOTAL = SYNC_LEN + BP_LEN + ACT_LEN + FP_LEN;
  localparam int B1    = SYNC_LEN;
  localparam int B2    = B1 + BP_LEN;
  localparam int B3    = B2 + ACT_LEN;

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] B1_C = CW'(B1);
  localparam logic [CW-1:0] B2_C = CW'(B2);
  localparam logic [CW-1:0] B3_C = CW'(B3);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_BP   = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_FP   = 2'd3;

  generate
    if (TOTAL > (1 << CW) || SYNC_LEN < 1 || BP_LEN < 1 ||
        ACT_LEN < 1 || FP_LEN < 1) begin : g_bad_cfg
      $error("sync_timing_gen: bad phase lengths or CW too small");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [CW-1:0] pos_q, pos_d;
  logic [1:0]    st_q, st_d;
  logic          sync_q, sync_d;
  logic          act_q, act_d;

  // Phase is decided from the next count so ST never lags CNT.
  always_comb begin
    cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    cnt_d   = cnt_q;
    st_d    = st_q;
    pos_d   = pos_q;
    if (CE) begin
      cnt_d = cnt_nxt;
      case (st_q)
        S_SYNC: if (cnt_nxt == B1_C) st_d = S_BP;
        S_BP:   if (cnt_nxt == B2_C) st_d = S_ACT;
        S_ACT:  if (cnt_nxt == B3_C) st_d = S_FP;
        S_FP:   if (cnt_nxt == '0)   st_d = S_SYNC;
        default: begin
          st_d  = S_SYNC;
          cnt_d = '0;
        end
      endcase
      pos_d = (st_q == S_ACT && st_d == S_ACT) ? pos_q + CW'(1) : '0;
    end
    sync_d = (st_d == S_SYNC) ? SYNC_POL : ~SYNC_POL;
    act_d  = (st_d == S_ACT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      st_q   <= S_SYNC;
      pos_q  <= '0;
      sync_q <= SYNC_POL;
      act_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      pos_q  <= pos_d;
      sync_q <= sync_d;
      act_q  <= act_d;
    end
  end

  assign CNT    = cnt_q;
  assign ST     = st_q;
  assign POS    = pos_q;
  assign SYNC   = sync_q;
  assign ACTIVE = act_q;
  assign EOL    = CE && (cnt_q == LAST);

endmodule

// File: tb/tb_sync_timing_gen.sv
// Scoreboard bench for sync_timing_gen: directed expectations keyed by
// cycle, checked by an independent negedge monitor.
module tb_sync_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_r = 1'b0;
  logic ce_on = 1'b1;
  logic ce_t = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       sync_w [9];
  logic [1:0] st_w   [9];
  logic       act_w  [9];
  logic [9:0] pos_w  [9];
  logic [9:0] cnt_w  [9];
  logic       eol_w  [9];
  logic [1:0] pos4, cnt4;
  logic [2:0] pos7, cnt7;

  assign pos_w[4] = 10'(pos4);
  assign cnt_w[4] = 10'(cnt4);
  assign pos_w[7] = 10'(pos7);
  assign cnt_w[7] = 10'(cnt7);

  sync_timing_gen u_h (
    .CLK(clk), .RST_N(rst_n), .CE(ce_on),
    .SYNC(sync_w[0]), .ST(st_w[0]), .ACTIVE(act_w[0]),
    .POS(pos_w[0]), .CNT(cnt_w[0]), .EOL(eol_w[0]));

  sync_timing_gen #(.SYNC_POL(1'b1)) u_p (
    .CLK(clk), .RST_N(rst_n), .CE(ce_on),
    .SYNC(sync_w[1]), .ST(st_w[1]), .ACTIVE(act_w[1]),
    .POS(pos_w[1]), .CNT(cnt_w[1]), .EOL(eol_w[1]));

  sync_timing_gen u_ce (
    .CLK(clk), .RST_N(rst_n), .CE(ce_t),
    .SYNC(sync_w[2]), .ST(st_w[2]), .ACTIVE(act_w[2]),
    .POS(pos_w[2]), .CNT(cnt_w[2]), .EOL(eol_w[2]));

  sync_timing_gen u_r (
    .CLK(clk), .RST_N(rst_r), .CE(ce_on),
    .SYNC(sync_w[3]), .ST(st_w[3]), .ACTIVE(act_w[3]),
    .POS(pos_w[3]), .CNT(cnt_w[3]), .EOL(eol_w[3]));

  sync_timing_gen #(.CW(2), .SYNC_LEN(1), .BP_LEN(1),
                    .ACT_LEN(1), .FP_LEN(1)) u_t (
    .CLK(clk), .RST_N(rst_n), .CE(ce_on),
    .SYNC(sync_w[4]), .ST(st_w[4]), .ACTIVE(act_w[4]),
    .POS(pos4), .CNT(cnt4), .EOL(eol_w[4]));

  sync_timing_gen u_hv (
    .CLK(clk), .RST_N(rst_n), .CE(ce_on),
    .SYNC(sync_w[5]), .ST(st_w[5]), .ACTIVE(act_w[5]),
    .POS(pos_w[5]), .CNT(cnt_w[5]), .EOL(eol_w[5]));

  sync_timing_gen #(.SYNC_LEN(2), .BP_LEN(33),
                    .ACT_LEN(480), .FP_LEN(10)) u_v (
    .CLK(clk), .RST_N(rst_n), .CE(eol_w[5]),
    .SYNC(sync_w[6]), .ST(st_w[6]), .ACTIVE(act_w[6]),
    .POS(pos_w[6]), .CNT(cnt_w[6]), .EOL(eol_w[6]));

  sync_timing_gen #(.CW(3), .SYNC_LEN(2), .BP_LEN(2),
                    .ACT_LEN(2), .FP_LEN(2)) u_sh (
    .CLK(clk), .RST_N(rst_n), .CE(ce_on),
    .SYNC(sync_w[7]), .ST(st_w[7]), .ACTIVE(act_w[7]),
    .POS(pos7), .CNT(cnt7), .EOL(eol_w[7]));

  sync_timing_gen #(.SYNC_LEN(2), .BP_LEN(33),
                    .ACT_LEN(480), .FP_LEN(10)) u_sv (
    .CLK(clk), .RST_N(rst_n), .CE(eol_w[7]),
    .SYNC(sync_w[8]), .ST(st_w[8]), .ACTIVE(act_w[8]),
    .POS(pos_w[8]), .CNT(cnt_w[8]), .EOL(eol_w[8]));

  typedef struct packed {
    logic [15:0] cnt;
    logic [1:0]  st;
    logic        sync;
    logic        act;
    logic [15:0] pos;
    logic        eol;
  } obs_t;

  typedef struct {
    int    cyc;
    int    dut;
    obs_t  exp;
    string name;
  } rec_t;

  rec_t sb[$];

  task automatic push(input int c, input int d, input int cnt,
                      input int st, input int sy, input int ac,
                      input int pos, input int eol, input string nm);
    rec_t r;
    r.cyc      = c;
    r.dut      = d;
    r.exp.cnt  = 16'(cnt);
    r.exp.st   = 2'(st);
    r.exp.sync = 1'(sy);
    r.exp.act  = 1'(ac);
    r.exp.pos  = 16'(pos);
    r.exp.eol  = 1'(eol);
    r.name     = nm;
    sb.push_back(r);
  endtask

  function automatic obs_t observe(input int d);
    obs_t o;
    o.cnt  = 16'(cnt_w[d]);
    o.st   = st_w[d];
    o.sync = sync_w[d];
    o.act  = act_w[d];
    o.pos  = 16'(pos_w[d]);
    o.eol  = eol_w[d];
    return o;
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs_t a;
        obs_t e;
        a = observe(sb[i].dut);
        e = sb[i].exp;
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s dut%0d cyc%0d: got cnt=%0d st=%0d sync=%0d act=%0d pos=%0d eol=%0d, expected cnt=%0d st=%0d sync=%0d act=%0d pos=%0d eol=%0d",
                   sb[i].name, sb[i].dut, cyc, a.cnt, a.st, a.sync,
                   a.act, a.pos, a.eol, e.cnt, e.st, e.sync,
                   e.act, e.pos, e.eol);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int b;
    push(2, 0, 0, 0, 0, 0, 0, 0, "rst_h");
    push(2, 1, 0, 0, 1, 0, 0, 0, "rst_pol");
    push(2, 4, 0, 0, 0, 0, 0, 0, "rst_tiny");
    push(2, 8, 0, 0, 0, 0, 0, 0, "rst_v");
    while (cyc < 3) @(negedge clk);

    n_chk++;
    if (cnt_w[0] !== 10'd0 || st_w[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL pre_rel_h: cnt=%0d st=%0d", cnt_w[0], st_w[0]);
    end
    n_chk++;
    if (sync_w[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rel_pol: sync=%0d", sync_w[1]);
    end
    n_chk++;
    if (act_w[0] !== 1'b0 || pos_w[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL pre_rel_act: act=%0d pos=%0d", act_w[0], pos_w[0]);
    end
    n_chk++;
    if (eol_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_rel_eol: eol=%0d", eol_w[0]);
    end

    base  = cyc;
    b     = base;
    rst_n = 1'b1;
    rst_r = 1'b1;

    push(b+1,    0, 1,   0, 0, 0, 0,   0, "h_first");
    push(b+95,   0, 95,  0, 0, 0, 0,   0, "h_sync_end");
    push(b+96,   0, 96,  1, 1, 0, 0,   0, "h_bp_start");
    push(b+143,  0, 143, 1, 1, 0, 0,   0, "h_bp_end");
    push(b+144,  0, 144, 2, 1, 1, 0,   0, "h_act_start");
    push(b+145,  0, 145, 2, 1, 1, 1,   0, "h_pos1");
    push(b+783,  0, 783, 2, 1, 1, 639, 0, "h_pos_max");
    push(b+784,  0, 784, 3, 1, 0, 0,   0, "h_fp_start");
    push(b+798,  0, 798, 3, 1, 0, 0,   0, "h_pre_eol");
    push(b+799,  0, 799, 3, 1, 0, 0,   1, "h_eol");
    push(b+800,  0, 0,   0, 0, 0, 0,   0, "h_wrap");
    push(b+1599, 0, 799, 3, 1, 0, 0,   1, "h_eol2");

    push(b+1,   1, 1,   0, 1, 0, 0, 0, "p_sync");
    push(b+95,  1, 95,  0, 1, 0, 0, 0, "p_sync_end");
    push(b+96,  1, 96,  1, 0, 0, 0, 0, "p_bp");
    push(b+799, 1, 799, 3, 0, 0, 0, 1, "p_eol");
    push(b+800, 1, 0,   0, 1, 0, 0, 0, "p_wrap");

    push(b+1,    2, 1,   0, 0, 0, 0, 0, "ce_tick");
    push(b+2,    2, 1,   0, 0, 0, 0, 0, "ce_hold");
    push(b+191,  2, 96,  1, 1, 0, 0, 0, "ce_bp");
    push(b+192,  2, 96,  1, 1, 0, 0, 0, "ce_bp_hold");
    push(b+288,  2, 144, 2, 1, 1, 0, 0, "ce_act");
    push(b+289,  2, 145, 2, 1, 1, 1, 0, "ce_pos1");
    push(b+290,  2, 145, 2, 1, 1, 1, 0, "ce_pos1_hold");
    push(b+1597, 2, 799, 3, 1, 0, 0, 0, "ce_eol_gated");
    push(b+1598, 2, 799, 3, 1, 0, 0, 1, "ce_eol");
    push(b+1599, 2, 0,   0, 0, 0, 0, 0, "ce_wrap");

    push(b+299, 3, 299, 2, 1, 1, 155, 0, "r_before");
    push(b+300, 3, 0,   0, 0, 0, 0,   0, "r_async");
    push(b+301, 3, 0,   0, 0, 0, 0,   0, "r_held");
    push(b+302, 3, 1,   0, 0, 0, 0,   0, "r_restart");
    push(b+397, 3, 96,  1, 1, 0, 0,   0, "r_bp");
    push(b+445, 3, 144, 2, 1, 1, 0,   0, "r_act");

    for (int k = 1; k <= 9; k++) begin
      int c;
      c = k % 4;
      push(b+k, 4, c, c, int'(c != 0), int'(c == 2), 0,
           int'(c == 3), "tiny");
    end

    push(b+799,  6, 0, 0, 0, 0, 0, 0, "v_hold");
    push(b+800,  6, 1, 0, 0, 0, 0, 0, "v_step1");
    push(b+1600, 6, 2, 1, 1, 0, 0, 0, "v_step2");
    push(b+2399, 6, 2, 1, 1, 0, 0, 0, "v_hold2");

    push(b+5,    7, 5,   2, 1, 1, 1,   0, "sh_act");
    push(b+4199, 7, 7,   3, 1, 0, 0,   1, "sh_eol");
    push(b+279,  8, 34,  1, 1, 0, 0,   0, "sv_bp_end");
    push(b+280,  8, 35,  2, 1, 1, 0,   0, "sv_act");
    push(b+4112, 8, 514, 2, 1, 1, 479, 0, "sv_act_end");
    push(b+4120, 8, 515, 3, 1, 0, 0,   0, "sv_fp");
    push(b+4198, 8, 524, 3, 1, 0, 0,   0, "sv_pre_eol");
    push(b+4199, 8, 524, 3, 1, 0, 0,   1, "sv_eol");
    push(b+4200, 8, 0,   0, 0, 0, 0,   0, "sv_wrap");

    fork
      forever begin
        @(posedge clk);
        #2 ce_t = ~ce_t;
      end
      begin
        wait (cyc == b + 300);
        #2 rst_r = 1'b0;
        @(posedge clk);
        #2 rst_r = 1'b1;
      end
    join_none

    repeat (4212) @(negedge clk);
    #1;
    foreach (sb[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s dut%0d: expired unchecked at cyc%0d, due cyc%0d",
               sb[i].name, sb[i].dut, cyc, sb[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_timing_gen.md
Name: sync_timing_gen

Overview:
- Parametrised successor to the fixed 800-count horizontal sync FSM.
- Owns its own position counter; no external count is needed.
- Generates the sync pulse, the 4-phase state, an active-video flag, the position within the active region, and an end-of-period strobe.
- One instance clocked every cycle gives horizontal timing. A second instance, whose CE is driven by the first instance's EOL, gives vertical timing.

Parameters:
- CW, 10, counter and position width; must satisfy TOTAL <= 2^CW (elaboration error otherwise).
- SYNC_LEN, 96, sync phase length in CE ticks (>=1).
- BP_LEN, 48, back-porch length (>=1).
- ACT_LEN, 640, active-region length (>=1).
- FP_LEN, 16, front-porch length (>=1).
- SYNC_POL, 0, level of SYNC during the sync phase; SYNC is ~SYNC_POL in all other phases.

Ports:
- CLK, input, 1, clock; all state changes on rising edge.
- RST_N, input, 1, asynchronous active-low reset.
- CE, input, 1, count enable; the counter advances only on edges where CE=1.
- SYNC, output, 1, sync pulse; polarity set by SYNC_POL.
- ST, output, 2, phase: 0=SYNC, 1=BP, 2=ACTIVE, 3=FP (legacy encoding).
- ACTIVE, output, 1, high while ST==2.
- POS, output, CW, index within the active region: 0..ACT_LEN-1 while ACTIVE, 0 otherwise.
- CNT, output, CW, raw period count 0..TOTAL-1.
- EOL, output, 1, combinational strobe: CE && CNT==TOTAL-1.

Behaviour:
- TOTAL = SYNC_LEN+BP_LEN+ACT_LEN+FP_LEN. Phase boundaries:
  - B1 = SYNC_LEN
  - B2 = B1+BP_LEN
  - B3 = B2+ACT_LEN
- Reset (RST_N=0, asynchronous, takes effect immediately, including mid-period):
  - CNT=0, ST=0, SYNC=SYNC_POL, ACTIVE=0, POS=0.
  - EOL=0 because CNT!=TOTAL-1 (TOTAL>=4).
- After reset release, the first CE tick moves CNT 0->1.
- CNT advance: on an edge with CE=1, CNT <= (CNT==TOTAL-1) ? 0 : CNT+1. With CE=0, all registers hold.
- FSM: ST, SYNC, ACTIVE and POS are registered. They update on the same edge as CNT and are always consistent with the current CNT. There is zero lag between CNT and phase (the legacy one-cycle lag is removed).
  - SYNC(0) -> BP when the next CNT == B1.
  - BP(1) -> ACTIVE when the next CNT == B2.
  - ACTIVE(2) -> FP when the next CNT == B3.
  - FP(3) -> SYNC when the next CNT == 0 (wrap).
  - No other transitions. Any illegal state forces SYNC with CNT=0 on the next CE edge.
- Phase extents, for a CNT value:
  - SYNC: 0..B1-1
  - BP: B1..B2-1
  - ACTIVE: B2..B3-1
  - FP: B3..TOTAL-1
- POS:
  - Loads 0 on entry to ACTIVE.
  - Increments by 1 on each CE tick while remaining in ACTIVE.
  - Forced to 0 on exit.
  - Never exceeds ACT_LEN-1; no wrap inside the active region.
- EOL:
  - High exactly one CE-qualified cycle per period.
  - If CE is held low while CNT==TOTAL-1, EOL stays 0 until the cycle in which CE is high.
- CE gaps: phase durations are counted in CE ticks, not clocks. A 1-tick phase (length param =1) is legal and lasts exactly one CE tick.
- All arithmetic is CW-bit unsigned. Comparisons use elaboration-time constants. No runtime division.

Test Plan:
- Defaults, CE=1, RST_N released at t0 -> SYNC=0 for CNT 0..95; ST=1 at CNT 96; ST=2 and ACTIVE=1 at CNT 144 with POS=0; POS=639 at CNT 783; ST=3 at CNT 784; EOL=1 only at CNT 799; CNT=0 and SYNC=0 on the next edge. Period = 800 clocks.
- SYNC_POL=1, defaults otherwise -> SYNC=1 for CNT 0..95, 0 for 96..799. ST identical to the first test.
- Chained pair (H defaults, V: CW=10, SYNC_LEN=2, BP_LEN=33, ACT_LEN=480, FP_LEN=10, CE=H.EOL) -> V.CNT increments once per 800 clocks; V.ST=2 from V.CNT 35 to 514; frame = 525*800 = 420000 clocks; V.EOL coincides with the H.EOL at V.CNT=524.
- CE toggled 1,0,1,0 with defaults -> every value of CNT/ST/POS lasts 2 clocks; EOL high for 1 clock only, in the CE=1 cycle at CNT 799.
- RST_N pulsed low asynchronously at CNT=300 (mid-active) -> outputs return to reset values with no clock edge; restart from CNT=0 with ST=0.
- SYNC_LEN=BP_LEN=ACT_LEN=FP_LEN=1, CW=2 -> ST sequence 0,1,2,3,0; POS stays 0; ACTIVE high 1 tick per 4; EOL every 4th tick.
